// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
//
// Shares one single-port synchronous video RAM between the display fetch path
// and a host (CPU) port. Display reads take fixed slots one word ahead of the
// beam, once every PX_PER_WORD pixels inside the fetch window. The host gets
// any cycle that is not a display slot, through a req/ack handshake that
// completes at most one access every two cycles.
//
// Optional feature:
//   VRAM_BLANK_ONLY_EN  when defined, the host is granted only outside the
//                       fetch window, so the visible image never tears.
//
// Ports:
//   clk          pixel clock
//   rstn         asynchronous active-low reset
//   hc, vc       horizontal / vertical counters from the sync generator
//   host_req     host request, held until host_ack
//   host_we      1 = write, 0 = read, stable while host_req is high
//   host_addr    host word address
//   host_wdata   host write data
//   host_ack     one-cycle completion pulse (registered)
//   host_rdata   read data, valid while host_ack is high
//   mem_en       RAM access enable
//   mem_we       RAM write enable
//   mem_addr     RAM word address
//   mem_wdata    RAM write data
//   mem_rdata    RAM read data, valid one cycle after a read is issued
//   disp_data    latest fetched display word (registered)
//   disp_valid   one-cycle pulse when disp_data updates
//
// Host FSM:
//   state  | meaning
//   S_IDLE | no host access in flight; may grant this cycle
//   S_ACK  | access granted last cycle; host_ack high, no new grant
// ---------------------------------------------------------------------------
module vram_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int PX_PER_WORD = 8,
  parameter int H_BLANK     = 160,
  parameter int V_BLANK     = 45,
  parameter int HPIXELS     = 800,
  parameter int VLINES      = 525
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [9:0]        hc,
  input  logic [9:0]        vc,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid
);

  localparam logic [9:0] WIN_H_LO = 10'(H_BLANK - PX_PER_WORD);
  localparam logic [9:0] WIN_H_HI = 10'(HPIXELS - PX_PER_WORD);
  localparam logic [9:0] WIN_V_LO = 10'(V_BLANK);
  localparam logic [9:0] WIN_V_HI = 10'(VLINES);
  localparam logic [9:0] WORD_MSK = 10'(PX_PER_WORD - 1);

  typedef enum logic {S_IDLE, S_ACK} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   disp_addr_q, disp_addr_d;
  logic                fetch_q;        // display read was issued last cycle
  logic                disp_valid_q;
  logic [DATA_W-1:0]   disp_data_q;

  logic                in_window;
  logic                disp_slot;
  logic                host_allowed;
  logic                grant;

  // Window is one word ahead of active video so the first word is ready
  // by the time the serializer needs it.
  assign in_window = (vc >= WIN_V_LO) && (vc < WIN_V_HI) &&
                     (hc >= WIN_H_LO) && (hc < WIN_H_HI);
  assign disp_slot = in_window && ((hc & WORD_MSK) == 10'd0);

`ifdef VRAM_BLANK_ONLY_EN
  assign host_allowed = !in_window;
`else
  assign host_allowed = 1'b1;
`endif

  // rstn gates the grant so nothing reaches the RAM while in reset.
  assign grant = rstn && (state_q == S_IDLE) && host_req &&
                 !disp_slot && host_allowed;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant) state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    host_ack  = (state_q == S_ACK);
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rstn && disp_slot) begin
      mem_en   = 1'b1;
      mem_addr = disp_addr_q;
    end else if (grant) begin
      mem_en    = 1'b1;
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
  end

  assign host_rdata = mem_rdata;

  // ---------------- display address and fetch pipeline ----------------
  // Linear word address: cleared at frame origin, bumped after each slot,
  // so no line*width multiply is needed.
  always_comb begin
    disp_addr_d = disp_addr_q;
    if (hc == 10'd0 && vc == 10'd0) disp_addr_d = '0;
    else if (disp_slot)             disp_addr_d = disp_addr_q + ADDR_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      disp_addr_q  <= '0;
      fetch_q      <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
    end else begin
      disp_addr_q  <= disp_addr_d;
      fetch_q      <= disp_slot;
      disp_valid_q <= fetch_q;
      if (fetch_q) disp_data_q <= mem_rdata;
    end
  end

  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [9:0]  hc = '0;
  logic [9:0]  vc = '0;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [15:0] host_addr = '0;
  logic [7:0]  host_wdata = '0;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic [7:0]  disp_data;
  logic        disp_valid;

  int n_cmp = 0;
  int n_fail = 0;

  vram_arbiter dut (
    .clk(clk), .rstn(rstn), .hc(hc), .vc(vc),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .disp_data(disp_data), .disp_valid(disp_valid)
  );

  always #5 clk = ~clk;

  // RAM model: unwritten words read back as the low byte of their address.
  bit [7:0] ram [65536];
  bit       ram_wr [65536];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]    <= mem_wdata;
        ram_wr[mem_addr] <= 1'b1;
      end
      mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : mem_addr[7:0];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t hc=%0d vc=%0d)", name, act, exp, $time, hc, vc);
    end
  endtask

  // One cycle: drive inputs after the falling edge, settle, caller checks.
  task automatic cyc(input logic [9:0] h, input logic [9:0] v, input logic r,
                     input logic w, input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    hc = h; vc = v; host_req = r; host_we = w; host_addr = a; host_wdata = d;
    #1;
  endtask

  // Display run with expectations from the frame geometry.
  logic       hist1 = 1'b0, hist2 = 1'b0;
  logic [7:0] dat1 = '0, dat2 = '0;

  task automatic disp_cycle(input int h, input int v);
    logic exp_slot;
    int   exp_addr;
    cyc(10'(h), 10'(v), 1'b0, 1'b0, 16'h0, 8'h0);
    exp_slot = (v >= 45) && (h >= 152) && (h < 792) && (h % 8 == 0);
    exp_addr = exp_slot ? (v - 45) * 80 + (h - 152) / 8 : 0;
    chk("disp_mem_en", 32'(mem_en), 32'(exp_slot));
    if (exp_slot) begin
      chk("disp_mem_addr", 32'(mem_addr), 32'(exp_addr));
      chk("disp_mem_we", 32'(mem_we), 32'd0);
    end
    chk("disp_valid", 32'(disp_valid), 32'(hist2));
    if (hist2) chk("disp_data", 32'(disp_data), 32'(dat2));
    hist2 = hist1; dat2 = dat1;
    hist1 = exp_slot; dat1 = exp_addr[7:0];
  endtask

  typedef struct {
    logic [9:0]  hc;
    logic [9:0]  vc;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        exp_en;
    logic        exp_we;
    logic [15:0] exp_addr;
    logic        exp_ack;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int acks;
    int bad;
    int k;

    vecs[0]  = '{10'd0,   10'd0,   1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[1]  = '{10'd10,  10'd10,  1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[2]  = '{10'd10,  10'd10,  1'b1, 1'b1, 16'h1234, 8'hA5, 1'b1, 1'b1, 16'h1234, 1'b1};
    vecs[3]  = '{10'd152, 10'd45,  1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0};
    vecs[4]  = '{10'd160, 10'd45,  1'b1, 1'b1, 16'h0007, 8'h5A, 1'b1, 1'b0, 16'h0001, 1'b0};
    vecs[5]  = '{10'd784, 10'd45,  1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0002, 1'b0};
    vecs[6]  = '{10'd792, 10'd45,  1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[7]  = '{10'd152, 10'd44,  1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[8]  = '{10'd155, 10'd45,  1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[9]  = '{10'd144, 10'd45,  1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[10] = '{10'd0,   10'd0,   1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[11] = '{10'd152, 10'd300, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0};
    vecs[12] = '{10'd792, 10'd300, 1'b1, 1'b0, 16'hFFFF, 8'h00, 1'b1, 1'b0, 16'hFFFF, 1'b1};

    // ---- reset with hc sweeping through a slot and host requesting ----
    for (int i = 0; i < 5; i++) begin
      cyc(10'(150 + i), 10'd45, 1'b1, 1'b1, 16'h0044, 8'h11);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_host_ack", 32'(host_ack), 32'd0);
      chk("rst_disp_valid", 32'(disp_valid), 32'd0);
      chk("rst_disp_data", 32'(disp_data), 32'd0);
    end
    @(negedge clk);
    host_req = 1'b0; hc = 10'd149; rstn = 1'b1;

    // ---- display run: line 45, start of line 46, frame wrap ----
    for (int h = 150; h < 800; h++) disp_cycle(h, 45);
    for (int h = 0; h <= 170; h++) disp_cycle(h, 46);
    disp_cycle(798, 524);
    disp_cycle(799, 524);
    disp_cycle(0, 0);
    disp_cycle(1, 0);
    for (int h = 150; h <= 170; h++) disp_cycle(h, 45);

    // ---- table of single-cycle decode vectors, each followed by an idle cycle ----
    foreach (vecs[i]) begin
      cyc(vecs[i].hc, vecs[i].vc, vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("tbl%0d_ack_pre", i), 32'(host_ack), 32'd0);
      chk($sformatf("tbl%0d_mem_en", i), 32'(mem_en), 32'(vecs[i].exp_en));
      if (vecs[i].exp_en) begin
        chk($sformatf("tbl%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].exp_we));
        chk($sformatf("tbl%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].exp_addr));
        if (vecs[i].exp_we)
          chk($sformatf("tbl%0d_mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].wdata));
      end
      cyc(10'd1, 10'd1, 1'b0, 1'b0, 16'h0, 8'h0);
      chk($sformatf("tbl%0d_ack", i), 32'(host_ack), 32'(vecs[i].exp_ack));
      chk($sformatf("tbl%0d_idle_en", i), 32'(mem_en), 32'd0);
    end

    // ---- readback of the blanking write (0x1234 <- 0xA5) ----
    cyc(10'd20, 10'd10, 1'b1, 1'b0, 16'h1234, 8'h00);
    chk("rb_mem_en", 32'(mem_en), 32'd1);
    chk("rb_mem_we", 32'(mem_we), 32'd0);
    chk("rb_mem_addr", 32'(mem_addr), 32'h1234);
    cyc(10'd21, 10'd10, 1'b1, 1'b0, 16'h1234, 8'h00);
    chk("rb_ack", 32'(host_ack), 32'd1);
    chk("rb_rdata", 32'(host_rdata), 32'hA5);
    chk("rb_no_reissue", 32'(mem_en), 32'd0);
    cyc(10'd22, 10'd10, 1'b0, 1'b0, 16'h0, 8'h0);
    chk("rb_ack_drop", 32'(host_ack), 32'd0);

`ifndef VRAM_BLANK_ONLY_EN
    // ---- collision: host request lands on the display slot at hc=160 ----
    cyc(10'd0, 10'd0, 1'b0, 1'b0, 16'h0, 8'h0);
    cyc(10'd152, 10'd45, 1'b0, 1'b0, 16'h0, 8'h0);
    chk("col_first_addr", 32'(mem_addr), 32'd0);
    for (int h = 153; h < 160; h++) cyc(10'(h), 10'd45, 1'b0, 1'b0, 16'h0, 8'h0);
    cyc(10'd160, 10'd45, 1'b1, 1'b0, 16'h0005, 8'h0);
    chk("col160_en", 32'(mem_en), 32'd1);
    chk("col160_we", 32'(mem_we), 32'd0);
    chk("col160_addr", 32'(mem_addr), 32'd1);
    chk("col160_ack", 32'(host_ack), 32'd0);
    cyc(10'd161, 10'd45, 1'b1, 1'b0, 16'h0005, 8'h0);
    chk("col161_en", 32'(mem_en), 32'd1);
    chk("col161_addr", 32'(mem_addr), 32'h0005);
    chk("col161_ack", 32'(host_ack), 32'd0);
    cyc(10'd162, 10'd45, 1'b1, 1'b0, 16'h0005, 8'h0);
    chk("col162_ack", 32'(host_ack), 32'd1);
    chk("col162_rdata", 32'(host_rdata), 32'h05);
    chk("col162_en", 32'(mem_en), 32'd0);
    cyc(10'd163, 10'd45, 1'b0, 1'b0, 16'h0, 8'h0);
    chk("col163_ack", 32'(host_ack), 32'd0);
`endif

    // ---- back-to-back: host_req held high over four reads ----
    acks = 0;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(10'(30 + i), 10'd20, 1'b1, 1'b0, 16'(16'h0100 + k), 8'h0);
      if (host_ack) acks++;
      chk("b2b_en", 32'(mem_en), 32'(i % 2 == 0));
      if (i % 2 == 0) begin
        chk("b2b_addr", 32'(mem_addr), 32'(16'h0100 + k));
        chk("b2b_ack_lo", 32'(host_ack), 32'd0);
      end else begin
        chk("b2b_ack_hi", 32'(host_ack), 32'd1);
        chk("b2b_rdata", 32'(host_rdata), 32'(k));
        k++;
      end
    end
    cyc(10'd38, 10'd20, 1'b0, 1'b0, 16'h0, 8'h0);
    if (host_ack) acks++;
    chk("b2b_ack_count", 32'(acks), 32'd4);

    // ---- reset asserted while an ack is pending ----
    cyc(10'd10, 10'd12, 1'b1, 1'b0, 16'h0003, 8'h0);
    chk("rmid_grant", 32'(mem_en), 32'd1);
    cyc(10'd11, 10'd12, 1'b1, 1'b0, 16'h0003, 8'h0);
    chk("rmid_ack_before", 32'(host_ack), 32'd1);
    rstn = 1'b0;
    #1;
    chk("rmid_ack_dropped", 32'(host_ack), 32'd0);
    chk("rmid_en_in_rst", 32'(mem_en), 32'd0);
    cyc(10'd12, 10'd12, 1'b0, 1'b0, 16'h0, 8'h0);
    rstn = 1'b1;
    cyc(10'd13, 10'd12, 1'b0, 1'b0, 16'h0, 8'h0);
    chk("rmid_no_ack", 32'(host_ack), 32'd0);
    cyc(10'd14, 10'd12, 1'b1, 1'b0, 16'h0003, 8'h0);
    chk("rmid_rereq_en", 32'(mem_en), 32'd1);
    cyc(10'd15, 10'd12, 1'b1, 1'b0, 16'h0003, 8'h0);
    chk("rmid_rereq_ack", 32'(host_ack), 32'd1);
    cyc(10'd16, 10'd12, 1'b0, 1'b0, 16'h0, 8'h0);

    // ---- host request in the middle of a visible line ----
`ifdef VRAM_BLANK_ONLY_EN
    bad = 0;
    for (int h = 300; h < 792; h++) begin
      cyc(10'(h), 10'd100, 1'b1, 1'b0, 16'h0009, 8'h0);
      if (host_ack !== 1'b0) bad++;
      if (mem_en !== (h % 8 == 0)) bad++;
      if (mem_en === 1'b1 && mem_addr === 16'h0009) bad++;
    end
    chk("blank_only_hold", 32'(bad), 32'd0);
    cyc(10'd792, 10'd100, 1'b1, 1'b0, 16'h0009, 8'h0);
    chk("blank_only_en792", 32'(mem_en), 32'd1);
    chk("blank_only_addr792", 32'(mem_addr), 32'h0009);
    cyc(10'd793, 10'd100, 1'b1, 1'b0, 16'h0009, 8'h0);
    chk("blank_only_ack793", 32'(host_ack), 32'd1);
    chk("blank_only_rdata", 32'(host_rdata), 32'h09);
`else
    bad = 0;
    cyc(10'd300, 10'd100, 1'b1, 1'b0, 16'h0009, 8'h0);
    chk("mid_line_en300", 32'(mem_en), 32'd1);
    chk("mid_line_addr300", 32'(mem_addr), 32'h0009);
    cyc(10'd301, 10'd100, 1'b1, 1'b0, 16'h0009, 8'h0);
    chk("mid_line_ack301", 32'(host_ack), 32'd1);
    chk("mid_line_rdata", 32'(host_rdata), 32'h09);
`endif
    cyc(10'd1, 10'd1, 1'b0, 1'b0, 16'h0, 8'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Arbitrates a single-port synchronous video RAM between the display fetch path and a host (CPU) access port. Driven by the pixel clock and the `hc`/`vc` counters of the sync generator. Schedules fixed display read slots one word ahead of the beam and grants leftover cycles to the host through a req/ack handshake. Sits between the sync generator, the video RAM and the pixel serializer.

## Interface
- `ADDR_W`, 16, VRAM word address width
- `DATA_W`, 8, VRAM word width; one bit per pixel
- `PX_PER_WORD`, 8, pixels per word; power of two; `H_BLANK` must be a multiple of it
- `H_BLANK`, 160, hidden pixels per line; active video starts at `hc == H_BLANK`
- `V_BLANK`, 45, hidden lines per frame
- `HPIXELS`, 800, total pixels per line
- `VLINES`, 525, total lines per frame

Ports:
- `clk`  in  1  pixel clock, 25 MHz
- `rstn`  in  1  asynchronous active-low reset
- `hc`  in  10  horizontal counter from the sync generator
- `vc`  in  10  vertical counter from the sync generator
- `host_req`  in  1  host request; held until `host_ack`
- `host_we`  in  1  1 = write, 0 = read; stable while `host_req` is high
- `host_addr`  in  ADDR_W  host word address
- `host_wdata`  in  DATA_W  host write data
- `host_ack`  out  1  one-cycle completion pulse
- `host_rdata`  out  DATA_W  read data; valid only while `host_ack` is high
- `mem_en`  out  1  RAM access enable
- `mem_we`  out  1  RAM write enable
- `mem_addr`  out  ADDR_W  RAM address
- `mem_wdata`  out  DATA_W  RAM write data
- `mem_rdata`  in  DATA_W  RAM read data; valid one cycle after a read is issued
- `disp_data`  out  DATA_W  latest fetched display word (registered)
- `disp_valid`  out  1  one-cycle pulse when `disp_data` updates

## Operation
- Fetch window: `vc >= V_BLANK` and `H_BLANK-PX_PER_WORD <= hc < HPIXELS-PX_PER_WORD`.
- Display slot: any cycle in the fetch window where `hc % PX_PER_WORD == 0`. That gives 80 slots per visible line.
- In a display slot, `mem_*` is driven combinationally: `mem_en=1`, `mem_we=0`, `mem_addr=disp_addr`. The display always wins the slot.
- `disp_addr` is a register:
  - cleared when `hc==0 && vc==0`
  - otherwise incremented by 1 after each display slot
  - runs 0..38399 per frame; no multiply is used.
- Display read issued in cycle t → `mem_rdata` valid in t+1 → `disp_data` registered and `disp_valid=1` in t+2.
- Host FSM has two states:
  - IDLE: grant the host when `host_req=1`, the cycle is not a display slot and the macro gate below allows it. Drive `mem_en=1`, `mem_we=host_we`, `mem_addr=host_addr`, `mem_wdata=host_wdata` combinationally. Go to ACK.
  - ACK: `host_ack=1` (registered); `host_rdata=mem_rdata` passthrough. No grant in this cycle, so the still-high `host_req` is never re-issued. Return to IDLE.
- Host throughput: at most one access every 2 cycles.
- If no grant is made and there is no display slot, `mem_en=0`.
- A host write that hits the same address as a display fetch is ordered by the cycle in which each is issued; no forwarding.

## Timing
- Reset values: `host_ack=0`, `disp_valid=0`, `disp_data=0`, `disp_addr=0`, FSM=IDLE. While `rstn=0`, `mem_en=0` and `mem_we=0`, regardless of `hc`.
- Reset asserted mid-access: any pending ack is dropped. The host must re-request after reset.
- Host latency: a grant in cycle t gives `host_ack` in t+1. Worst-case wait without the macro is 1 cycle (display slot collision).
- First display fetch of line `V_BLANK`: `hc=152`, addr 0, `disp_valid` at `hc=154`. Last fetch of the line: `hc=784`, addr 79.
- Counter wrap: `hc` 799→0 and `vc` 524→0 need no special handling beyond clearing `disp_addr` at (0,0).

## Configuration
- `VRAM_BLANK_ONLY_EN` defined: the host is granted only outside the fetch window. This gives tear-free updates; worst-case host wait is about 640 + 8 cycles.
- Not defined: the host is granted in any non-slot cycle.

## Test plan
- Reset: hold `rstn=0` for 5 cycles with `hc` sweeping → `mem_en=0`, `host_ack=0`, `disp_valid=0`, `disp_data=0`. Release → first fetch addr 0 at (152,45).
- Display sequence: preload RAM[i]=i[7:0], run one frame →
  - line 45 fetches addr 0..79 at `hc=152,160..784`
  - `disp_data` values 0..79, each 2 cycles after its fetch
  - line 46 starts at addr 80
  - next frame restarts at addr 0.
- Host write in blanking: `host_req=1`, `host_we=1`, addr 0x1234, data 0xA5 at (hc 10, vc 10) → `mem_we=1` with addr 0x1234 the same cycle, `host_ack` next cycle. A readback returns 0xA5 in the ack cycle.
- Collision: `host_req` raised at (160,45) → display fetch at 160, host issued at 161, `host_ack` at 162.
- Back-to-back: `host_req` held high across 4 reads in blanking → grants at t, t+2, t+4, t+6; exactly 4 `host_ack` pulses.
- Macro on: `host_req` at (300,100) → no grant until `hc=792` of line 100, `host_ack` at `hc=793`. Macro off: `host_ack` at `hc=301`.
